// File: rtl/ysyx_22040750_mem_arb.sv
// Memory-port arbiter: one single-beat, single-outstanding memory port shared by IF and LSU.
// LSU has fixed priority; a saturating counter forces an IF grant after STARVE_LIMIT LSU wins.
module ysyx_22040750_mem_arb #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                I_sys_clk,
   input  logic                I_rst_n,
   input  logic                I_if_req_valid,
   output logic                O_if_req_ready,
   input  logic [ADDR_W-1:0]   I_if_addr,
   output logic                O_if_rvalid,
   output logic [31:0]         O_if_rdata,
   input  logic                I_ls_req_valid,
   output logic                O_ls_req_ready,
   input  logic [ADDR_W-1:0]   I_ls_addr,
   input  logic                I_ls_wen,
   input  logic [DATA_W-1:0]   I_ls_wdata,
   input  logic [DATA_W/8-1:0] I_ls_wmask,
   output logic                O_ls_rvalid,
   output logic [DATA_W-1:0]   O_ls_rdata,
   output logic                O_mem_req_valid,
   input  logic                I_mem_req_ready,
   output logic [ADDR_W-1:0]   O_mem_addr,
   output logic                O_mem_wen,
   output logic [DATA_W-1:0]   O_mem_wdata,
   output logic [DATA_W/8-1:0] O_mem_wmask,
   input  logic                I_mem_rvalid,
   input  logic [DATA_W-1:0]   I_mem_rdata
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [2:0] {
      IDLE,
      IF_REQ,
      IF_RESP,
      LS_REQ,
      LS_RESP
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] starve_q;
   logic             addr2_q;
   logic             starveFull;
   logic             lsWins;

   assign starveFull = (starve_q == STARVE_MAX);
   assign lsWins     = I_ls_req_valid && !(I_if_req_valid && starveFull);

   // Grant is decided in IDLE and takes effect next cycle; no preemption once granted.
   always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q  <= IDLE;
         starve_q <= '0;
         addr2_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (lsWins) begin
                  state_q <= LS_REQ;
                  if (!I_if_req_valid) begin
                     starve_q <= '0;
                  end else if (!starveFull) begin
                     starve_q <= starve_q + CNT_W'(1);
                  end
               end else if (I_if_req_valid) begin
                  state_q  <= IF_REQ;
                  starve_q <= '0;
               end
            end
            IF_REQ: begin
               if (!I_if_req_valid) begin
                  state_q <= IDLE;
               end else if (I_mem_req_ready) begin
                  state_q <= IF_RESP;
                  addr2_q <= I_if_addr[2];
               end
            end
            IF_RESP: begin
               if (I_mem_rvalid) begin
                  state_q <= IDLE;
               end
            end
            LS_REQ: begin
               if (!I_ls_req_valid) begin
                  state_q <= IDLE;
               end else if (I_mem_req_ready) begin
                  state_q <= LS_RESP;
               end
            end
            LS_RESP: begin
               if (I_mem_rvalid) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Request and response paths are combinational pass-throughs of the owning requester.
   always_comb begin
      O_if_req_ready  = 1'b0;
      O_ls_req_ready  = 1'b0;
      O_if_rvalid     = 1'b0;
      O_if_rdata      = '0;
      O_ls_rvalid     = 1'b0;
      O_ls_rdata      = '0;
      O_mem_req_valid = 1'b0;
      O_mem_addr      = '0;
      O_mem_wen       = 1'b0;
      O_mem_wdata     = '0;
      O_mem_wmask     = '0;
      case (state_q)
         IF_REQ: begin
            O_mem_req_valid = I_if_req_valid;
            O_mem_addr      = I_if_addr;
            O_if_req_ready  = I_mem_req_ready;
         end
         IF_RESP: begin
            O_if_rvalid = I_mem_rvalid;
            O_if_rdata  = addr2_q ? I_mem_rdata[32 +: 32] : I_mem_rdata[0 +: 32];
         end
         LS_REQ: begin
            O_mem_req_valid = I_ls_req_valid;
            O_mem_addr      = I_ls_addr;
            O_mem_wen       = I_ls_wen;
            O_mem_wdata     = I_ls_wdata;
            O_mem_wmask     = I_ls_wmask;
            O_ls_req_ready  = I_mem_req_ready;
         end
         LS_RESP: begin
            O_ls_rvalid = I_mem_rvalid;
            O_ls_rdata  = I_mem_rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/ysyx_22040750_mem_arb.md
Name:
ysyx_22040750_mem_arb

Overview:
Memory-port arbiter for the pipelined core. It shares a single data-memory/bus port between the IF stage (instruction fetch) and the LSU (MEM stage load/store). It sits between those two requesters and the memory interface. Transactions are single-beat with one outstanding at a time; the LSU has fixed priority, and a starvation guard protects IF.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 64, memory data width; the IF instruction is 32 bits, selected from it
STARVE_LIMIT, 4, consecutive LSU grants allowed while IF is waiting before IF is forced

Ports:
I_sys_clk  input  1  clock
I_rst_n  input  1  asynchronous active-low reset
I_if_req_valid  input  1  IF fetch request
O_if_req_ready  output  1  IF request accepted this cycle
I_if_addr  input  ADDR_W  fetch address
O_if_rvalid  output  1  instruction returned
O_if_rdata  output  32  instruction: I_mem_rdata[63:32] when latched addr[2]=1, else [31:0]
I_ls_req_valid  input  1  LSU request
O_ls_req_ready  output  1  LSU request accepted this cycle
I_ls_addr  input  ADDR_W  load/store address
I_ls_wen  input  1  1 = store
I_ls_wdata  input  DATA_W  store data
I_ls_wmask  input  DATA_W/8  store byte mask
O_ls_rvalid  output  1  load data / store ack
O_ls_rdata  output  DATA_W  load data
O_mem_req_valid  output  1  request to memory
I_mem_req_ready  input  1  memory accepts request
O_mem_addr  output  ADDR_W  muxed address
O_mem_wen  output  1  muxed write enable (0 for IF)
O_mem_wdata  output  DATA_W  muxed write data (0 for IF)
O_mem_wmask  output  DATA_W/8  muxed mask (0 for IF)
I_mem_rvalid  input  1  response valid
I_mem_rdata  input  DATA_W  response data

Behaviour:
- FSM states: IDLE, IF_REQ, IF_RESP, LS_REQ, LS_RESP. On reset (async, I_rst_n=0): state=IDLE, starvation counter=0, addr[2] latch=0. All outputs are 0 while in IDLE with no response.
- IDLE: the grant decision is registered, so the REQ state is entered on the next clock.
  - LS valid only -> LS_REQ. IF valid only -> IF_REQ.
  - Both valid -> LS_REQ, unless counter==STARVE_LIMIT, in which case -> IF_REQ.
- Starvation counter:
  - +1 on each LS grant made while I_if_req_valid=1 (saturating at STARVE_LIMIT).
  - Cleared on any IF grant, or on an LS grant made while IF is idle.
- x_REQ: O_mem_req_valid = I_x_req_valid. O_mem_* is driven combinationally from requester x. O_x_req_ready = I_mem_req_ready. The other requester's ready is 0.
  - Handshake (valid&ready) -> x_RESP; IF latches addr[2].
  - If I_x_req_valid drops before the handshake (flush), return to IDLE; nothing is issued.
- x_RESP: O_x_rvalid = I_mem_rvalid; rdata passes through combinationally. O_mem_req_valid=0. Both ready outputs are 0.
  - I_mem_rvalid=1 -> IDLE.
  - A new request therefore waits at least 1 idle cycle (IDLE→REQ). Minimum cost is 3 cycles per transaction when memory is ready/rvalid in the same cycle it is sampled.
- I_mem_rvalid outside a RESP state is ignored. It is never forwarded.
- Stores also complete via I_mem_rvalid (ack); O_ls_rdata is don't-care for stores.
- Exactly one outstanding transaction. No preemption once in a REQ or RESP state.
- Reset mid-transaction aborts immediately to IDLE. Any in-flight response is dropped.

Test Plan:
1. Reset with I_rst_n=0 asynchronously mid-LS_RESP -> outputs 0 and state IDLE with no clock edge. After release, an IF request at 0x30000000 is granted on the 2nd cycle; O_mem_addr=0x30000000, O_mem_wen=0.
2. IF fetch at 0x30000004 with memory returning 0x1111_2222_3333_4444 -> O_if_rdata=0x11112222 with O_if_rvalid for exactly 1 cycle.
3. Simultaneous IF and LS requests; LS is a store at 0x80000008 with wdata 0xDEADBEEF, wmask 0x0F -> LS is granted first with O_mem_wen=1 and mask 0x0F. IF is granted after the LS ack.
4. LS held continuously valid with IF also valid -> exactly STARVE_LIMIT(4) LS grants, then 1 IF grant, then LS resumes.
5. IF in IF_REQ with I_mem_req_ready=0; I_if_req_valid is then dropped (flush) -> O_mem_req_valid falls the same cycle, FSM returns to IDLE, and no O_if_rvalid is produced.
6. Stray I_mem_rvalid pulse in IDLE -> O_if_rvalid and O_ls_rvalid remain 0.
